// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter and its consumers.
// Holds the requester-id width helper and the default requester-id type
// that FIFO readers use to decode the OUT_id tag stored with each beat.
package fifo_arb_pkg;

   // Width of a requester index; never narrower than one bit.
   function automatic int IdWidth(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   localparam int NumReqDefault = 4;

   // Requester id as seen by FIFO consumers of the default configuration.
   typedef logic [IdWidth(NumReqDefault)-1:0] req_id_t;

endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// Handshake bundle between NUM_REQ producers, the arbiter and one FIFO write port.
// IN_* are driven by producers / the FIFO, OUT_* by the arbiter.
// slave: arbiter side; master: environment side (producers + FIFO).
interface fifo_rr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int NUM_REQ  = 4,
   parameter int FIFO_NUM = 4
);
   localparam int IdW   = IdWidth(NUM_REQ);
   localparam int FreeW = $clog2(FIFO_NUM) + 1;

   logic [NUM_REQ-1:0]            IN_valid;
   logic [NUM_REQ-1:0][WIDTH-1:0] IN_data;
   logic [NUM_REQ-1:0]            IN_last;
   logic [NUM_REQ-1:0]            OUT_ready;
   logic [FreeW-1:0]              IN_free;
   logic                          OUT_valid;
   logic [WIDTH-1:0]              OUT_data;
   logic [IdW-1:0]                OUT_id;
   logic                          IN_ready;
   logic                          OUT_locked;
   logic                          OUT_overrun;

   modport slave (
      input  IN_valid, IN_data, IN_last, IN_free, IN_ready,
      output OUT_ready, OUT_valid, OUT_data, OUT_id, OUT_locked, OUT_overrun
   );

   modport master (
      output IN_valid, IN_data, IN_last, IN_free, IN_ready,
      input  OUT_ready, OUT_valid, OUT_data, OUT_id, OUT_locked, OUT_overrun
   );

endinterface

// File: rtl/rr_priority_pick.sv
// Rotating priority pick: first set bit of req at or after base, wrapping.
// Latency: purely combinational.
// Ports: req (request vector), base (start index), valid (any hit), idx (winner).
module rr_priority_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = IdWidth(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    base,
   output logic               valid,
   output logic [ID_W-1:0]    idx
);

   always_comb begin
      int j;
      valid = 1'b0;
      idx   = '0;
      j     = 0;
      // Walk NUM_REQ positions starting at base; explicit wrap keeps
      // non-power-of-2 requester counts correct.
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(base) + k;
         if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
         end
         if (!valid && req[j]) begin
            valid = 1'b1;
            idx   = ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Latency: zero; grant, data mux and OUT_ready are combinational in the cycle of transfer.
// Backpressure: FIFO IN_ready routes to the granted producer only; new packets wait for IN_free >= MIN_FREE.
// Ports: clk, rst_n (async active-low), bus (slave side of fifo_rr_arbiter_if).
module fifo_rr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int NUM_REQ   = 4,
   parameter int FIFO_NUM  = 4,
   parameter int MIN_FREE  = 2,
   parameter int MAX_BEATS = 8
) (
   input logic              clk,
   input logic              rst_n,
   fifo_rr_arbiter_if.slave bus
);

   localparam int IdW   = IdWidth(NUM_REQ);
   localparam int FreeW = $clog2(FIFO_NUM) + 1;
   localparam int BeatW = $clog2(MAX_BEATS + 1);

   localparam logic [IdW-1:0]   LastId    = IdW'(NUM_REQ - 1);
   localparam logic [BeatW-1:0] FinalBeat = BeatW'(MAX_BEATS - 1);
   localparam logic [FreeW-1:0] MinFree   = FreeW'(MIN_FREE);

   typedef enum logic {IDLE, LOCKED} ArbState_t;

   ArbState_t        state, state_nxt;
   logic [IdW-1:0]   ptr, ptr_nxt;
   logic [IdW-1:0]   owner, owner_nxt;
   logic [BeatW-1:0] beats, beats_nxt;
   logic             overrun, overrun_nxt;

   logic               free_ok;
   logic [NUM_REQ-1:0] eligible;
   logic               pick_vld;
   logic [IdW-1:0]     pick_idx;
   logic               grant_vld;
   logic [IdW-1:0]     gidx;
   logic               g_valid;
   logic               g_last;
   logic [WIDTH-1:0]   g_data;
   logic               xfer;

   // Round-robin successor with explicit wrap (no power-of-2 truncation).
   function automatic logic [IdW-1:0] next_id(input logic [IdW-1:0] id);
      return (id == LastId) ? '0 : id + 1'b1;
   endfunction

   // Free-space gate applies only to packet starts, i.e. the IDLE pick.
   assign free_ok  = (bus.IN_free >= MinFree);
   assign eligible = bus.IN_valid & {NUM_REQ{free_ok}};

   rr_priority_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (IdW)
   ) u_pick (
      .req   (eligible),
      .base  (ptr),
      .valid (pick_vld),
      .idx   (pick_idx)
   );

   // Grant: the owner holds the port while LOCKED even with no valid beat
   // (bubble). Nothing is granted while reset is asserted.
   always_comb begin
      grant_vld = 1'b0;
      gidx      = '0;
      if (rst_n) begin
         if (state == LOCKED) begin
            grant_vld = 1'b1;
            gidx      = owner;
         end else begin
            grant_vld = pick_vld;
            gidx      = pick_idx;
         end
      end
   end

   // Mux the granted requester's beat; all zero while nothing is granted.
   always_comb begin
      g_valid = 1'b0;
      g_last  = 1'b0;
      g_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_vld && (gidx == IdW'(i))) begin
            g_valid = bus.IN_valid[i];
            g_last  = bus.IN_last[i];
            g_data  = bus.IN_data[i];
         end
      end
   end

   assign xfer = g_valid && bus.IN_ready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= '0;
         owner   <= '0;
         beats   <= '0;
         overrun <= 1'b0;
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         owner   <= owner_nxt;
         beats   <= beats_nxt;
         overrun <= overrun_nxt;
      end
   end

   // Next-state logic. Only a completed transfer moves anything; a stalled
   // IDLE grant is recomputed every cycle.
   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      owner_nxt   = owner;
      beats_nxt   = beats;
      overrun_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (xfer) begin
               if (g_last) begin
                  ptr_nxt = next_id(gidx);
               end else if (MAX_BEATS == 1) begin
                  // A one-beat limit means any non-last beat already overruns.
                  overrun_nxt = 1'b1;
                  ptr_nxt     = next_id(gidx);
               end else begin
                  state_nxt = LOCKED;
                  owner_nxt = gidx;
                  beats_nxt = BeatW'(1);
               end
            end
         end
         LOCKED: begin
            if (xfer) begin
               if (g_last || (beats == FinalBeat)) begin
                  // Normal end, or the MAX_BEATS-th beat was not last:
                  // release the port and flag the runaway packet.
                  state_nxt   = IDLE;
                  ptr_nxt     = next_id(owner);
                  beats_nxt   = '0;
                  overrun_nxt = !g_last;
               end else begin
                  beats_nxt = beats + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs. OUT_valid is independent of IN_ready by construction.
   always_comb begin
      bus.OUT_valid   = g_valid;
      bus.OUT_data    = g_data;
      bus.OUT_id      = gidx;
      bus.OUT_locked  = (state == LOCKED);
      bus.OUT_overrun = overrun;
      bus.OUT_ready   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.OUT_ready[i] = grant_vld && (gidx == IdW'(i)) && bus.IN_ready;
      end
   end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter (NUM_REQ=4, WIDTH=32, FIFO_NUM=4, MIN_FREE=2, MAX_BEATS=8).
// Inputs change 1 ns after posedge; outputs are sampled 1 ns later, well away from clock edges.
module tb_fifo_rr_arbiter;

   logic clk;
   logic rst_n;
   int   vectors;
   int   fails;

   fifo_rr_arbiter_if #(.WIDTH(32), .NUM_REQ(4), .FIFO_NUM(4)) ifc ();

   fifo_rr_arbiter #(
      .WIDTH     (32),
      .NUM_REQ   (4),
      .FIFO_NUM  (4),
      .MIN_FREE  (2),
      .MAX_BEATS (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] dat(input int r, input int b);
      return 32'hD000_0000 | (32'(r) << 8) | 32'(b);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input string tag, input int id, input logic [31:0] d,
                       input logic [3:0] rdy, input logic locked);
      chk({tag, "_valid"},  64'(ifc.OUT_valid),  64'd1);
      chk({tag, "_id"},     64'(ifc.OUT_id),     64'(id));
      chk({tag, "_data"},   64'(ifc.OUT_data),   64'(d));
      chk({tag, "_ready"},  64'(ifc.OUT_ready),  64'(rdy));
      chk({tag, "_locked"}, 64'(ifc.OUT_locked), 64'(locked));
   endtask

   task automatic set_req(input int r, input logic v, input logic [31:0] d, input logic l);
      ifc.IN_valid[r] = v;
      ifc.IN_data[r]  = d;
      ifc.IN_last[r]  = l;
   endtask

   task automatic clear_all();
      for (int r = 0; r < 4; r++) set_req(r, 1'b0, 32'd0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors      = 0;
      fails        = 0;
      rst_n        = 1'b0;
      ifc.IN_valid = '0;
      ifc.IN_data  = '0;
      ifc.IN_last  = '0;
      ifc.IN_free  = 3'd4;
      ifc.IN_ready = 1'b1;

      // Reset state
      #12;
      chk("rst_locked",  64'(ifc.OUT_locked),  64'd0);
      chk("rst_overrun", 64'(ifc.OUT_overrun), 64'd0);
      chk("rst_valid",   64'(ifc.OUT_valid),   64'd0);
      chk("rst_ready",   64'(ifc.OUT_ready),   64'd0);
      chk("rst_data",    64'(ifc.OUT_data),    64'd0);
      chk("rst_id",      64'(ifc.OUT_id),      64'd0);
      rst_n = 1'b1;
      tick();

      // All four requesters with single-beat packets: 0,1,2,3,0
      for (int r = 0; r < 4; r++) set_req(r, 1'b1, dat(r, 0), 1'b1);
      for (int i = 0; i < 5; i++) begin
         #1;
         beat("rr", i % 4, dat(i % 4, 0), 4'(1 << (i % 4)), 1'b0);
         tick();
      end
      clear_all();   // ptr now 1

      // Req1 3-beat packet while req0 and req2 wait
      set_req(0, 1'b1, dat(0, 1), 1'b1);
      set_req(2, 1'b1, dat(2, 1), 1'b1);
      set_req(1, 1'b1, dat(1, 0), 1'b0);
      #1; beat("pkt_b0", 1, dat(1, 0), 4'b0010, 1'b0); tick();
      set_req(1, 1'b1, dat(1, 1), 1'b0);
      #1; beat("pkt_b1", 1, dat(1, 1), 4'b0010, 1'b1); tick();
      set_req(1, 1'b1, dat(1, 2), 1'b1);
      #1; beat("pkt_b2", 1, dat(1, 2), 4'b0010, 1'b1); tick();
      set_req(1, 1'b0, 32'd0, 1'b0);
      #1; beat("pkt_next", 2, dat(2, 1), 4'b0100, 1'b0); tick();
      clear_all();   // ptr now 3

      // Free-space gate blocks a packet start, not a packet in progress
      ifc.IN_free = 3'd1;
      set_req(3, 1'b1, dat(3, 0), 1'b0);
      #1;
      chk("gate_valid", 64'(ifc.OUT_valid), 64'd0);
      chk("gate_ready", 64'(ifc.OUT_ready), 64'd0);
      chk("gate_data",  64'(ifc.OUT_data),  64'd0);
      chk("gate_id",    64'(ifc.OUT_id),    64'd0);
      tick();
      ifc.IN_free = 3'd4;
      #1; beat("gate_open", 3, dat(3, 0), 4'b1000, 1'b0); tick();
      ifc.IN_free = 3'd0;
      set_req(3, 1'b1, dat(3, 1), 1'b0);
      #1; beat("free_mid1", 3, dat(3, 1), 4'b1000, 1'b1); tick();
      set_req(3, 1'b1, dat(3, 2), 1'b1);
      #1; beat("free_mid2", 3, dat(3, 2), 4'b1000, 1'b1); tick();
      ifc.IN_free = 3'd4;
      clear_all();   // ptr now 0

      // FIFO stalls for 3 cycles mid-packet
      set_req(0, 1'b1, dat(0, 2), 1'b0);
      #1; beat("stall_b0", 0, dat(0, 2), 4'b0001, 1'b0); tick();
      set_req(0, 1'b1, dat(0, 3), 1'b0);
      set_req(1, 1'b1, dat(1, 3), 1'b1);
      ifc.IN_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_valid",  64'(ifc.OUT_valid),  64'd1);
         chk("stall_ready",  64'(ifc.OUT_ready),  64'd0);
         chk("stall_data",   64'(ifc.OUT_data),   64'(dat(0, 3)));
         chk("stall_locked", 64'(ifc.OUT_locked), 64'd1);
         tick();
      end
      ifc.IN_ready = 1'b1;
      #1; beat("stall_rel", 0, dat(0, 3), 4'b0001, 1'b1); tick();
      set_req(0, 1'b1, dat(0, 4), 1'b1);
      #1; beat("stall_b2", 0, dat(0, 4), 4'b0001, 1'b1); tick();
      set_req(0, 1'b0, 32'd0, 1'b0);
      #1; beat("stall_next", 1, dat(1, 3), 4'b0010, 1'b0); tick();
      clear_all();   // ptr now 2

      // Runaway packet: 8 non-last beats pass, overrun pulses after the 8th
      for (int b = 0; b < 8; b++) begin
         set_req(0, 1'b1, dat(0, b), 1'b0);
         #1;
         beat("ovr_beat", 0, dat(0, b), 4'b0001, (b != 0));
         chk("ovr_quiet", 64'(ifc.OUT_overrun), 64'd0);
         tick();
      end
      set_req(0, 1'b1, dat(0, 8), 1'b0);
      set_req(1, 1'b1, dat(1, 4), 1'b1);
      #1;
      chk("ovr_pulse_hi", 64'(ifc.OUT_overrun), 64'd1);
      beat("ovr_next", 1, dat(1, 4), 4'b0010, 1'b0);
      tick();
      set_req(1, 1'b0, 32'd0, 1'b0);
      #1;
      chk("ovr_pulse_lo", 64'(ifc.OUT_overrun), 64'd0);
      beat("ovr_restart", 0, dat(0, 8), 4'b0001, 1'b0);
      tick();   // LOCKED on req0, ptr 2

      // Asynchronous reset during a locked packet
      set_req(0, 1'b1, dat(0, 9), 1'b0);
      set_req(2, 1'b1, dat(2, 5), 1'b1);
      #1;
      beat("pre_rst", 0, dat(0, 9), 4'b0001, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("arst_locked", 64'(ifc.OUT_locked), 64'd0);
      chk("arst_valid",  64'(ifc.OUT_valid),  64'd0);
      chk("arst_ready",  64'(ifc.OUT_ready),  64'd0);
      tick();
      rst_n = 1'b1;
      #1;
      beat("arst_restart", 0, dat(0, 9), 4'b0001, 1'b0);
      chk("arst_overrun", 64'(ifc.OUT_overrun), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
